// File: rtl/conv2_window_reader_if.sv
// Control, BRAM port-B and pixel-stream bundle for the 2D convolution window reader.
interface conv2_window_reader_if;
  logic        start;
  logic [11:0] base_addr;
  logic        busy;
  logic        done;
  logic        enb;
  logic        web;
  logic [11:0] addrb;
  logic [7:0]  datain0;
  logic [7:0]  datain1;
  logic [7:0]  datain2;
  logic [7:0]  datain3;
  logic [7:0]  pix0;
  logic [7:0]  pix1;
  logic [7:0]  pix2;
  logic [7:0]  pix3;
  logic        pix_valid;
  logic        pix_ready;
  logic        win_first;
  logic        win_last;
  logic        frame_last;

  // Window reader side.
  modport slave (
    input  start, base_addr, datain0, datain1, datain2, datain3, pix_ready,
    output busy, done, enb, web, addrb, pix0, pix1, pix2, pix3,
           pix_valid, win_first, win_last, frame_last
  );

  // Controller / BRAM / pixel consumer side.
  modport master (
    output start, base_addr, datain0, datain1, datain2, datain3, pix_ready,
    input  busy, done, enb, web, addrb, pix0, pix1, pix2, pix3,
           pix_valid, win_first, win_last, frame_last
  );
endinterface

// File: rtl/conv2_window_reader.sv
// Walks every KxK window of a feature map in raster order, reads the four
// channels of each window pixel from BRAM port B (1-cycle latency) and streams
// them out through a 2-entry FIFO with valid/ready flow control.
module conv2_window_reader #(
  parameter int IMG_W = 24,
  parameter int IMG_H = 24,
  parameter int K     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  conv2_window_reader_if.slave  bus
);
  localparam int            CW    = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H) + 1;
  localparam logic [CW-1:0] KMAX  = CW'(K - 1);
  localparam logic [CW-1:0] OXMAX = CW'(IMG_W - K);
  localparam logic [CW-1:0] OYMAX = CW'(IMG_H - K);
  localparam int            EW    = 35;  // four 8-bit channels + three flags

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [11:0]   r_base;
  logic [CW-1:0] r_ox, r_oy, r_kx, r_ky;
  logic          r_vld_p1;
  logic [2:0]    r_flags_p1;
  logic [EW-1:0] r_mem [2];
  logic          r_wp, r_rp;
  logic [1:0]    r_cnt;

  logic          w_issue, w_pop, w_push, w_drained;
  logic          w_win_first, w_win_last, w_frame_last;
  logic [1:0]    w_occ;
  logic [11:0]   w_addr;
  logic [EW-1:0] w_head;

  assign w_addr = r_base + 12'((int'(r_oy) + int'(r_ky)) * IMG_W + int'(r_ox) + int'(r_kx));

  assign w_win_first  = (r_ky == '0) && (r_kx == '0);
  assign w_win_last   = (r_ky == KMAX) && (r_kx == KMAX);
  assign w_frame_last = w_win_last && (r_ox == OXMAX) && (r_oy == OYMAX);

  assign w_pop  = (r_cnt != 2'd0) && bus.pix_ready;
  assign w_push = r_vld_p1;
  // Buffered plus in-flight entries, with this cycle's pop already released.
  assign w_occ  = r_cnt + {1'b0, r_vld_p1} - {1'b0, w_pop};
  // Nothing left after this cycle: no read returning, FIFO empty or emptying now.
  assign w_drained = !r_vld_p1 && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic and read issue decision.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN: begin
        w_issue = (w_occ < 2'd2);
        if (w_issue && w_frame_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: if (w_drained) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Base capture and window position counters, kx fastest, oy slowest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base <= '0;
      r_ox   <= '0;
      r_oy   <= '0;
      r_kx   <= '0;
      r_ky   <= '0;
    end else if ((r_state == S_IDLE) && bus.start) begin
      r_base <= bus.base_addr;
      r_ox   <= '0;
      r_oy   <= '0;
      r_kx   <= '0;
      r_ky   <= '0;
    end else if (w_issue) begin
      if (r_kx != KMAX) begin
        r_kx <= r_kx + 1'b1;
      end else begin
        r_kx <= '0;
        if (r_ky != KMAX) begin
          r_ky <= r_ky + 1'b1;
        end else begin
          r_ky <= '0;
          if (r_ox != OXMAX) begin
            r_ox <= r_ox + 1'b1;
          end else begin
            r_ox <= '0;
            r_oy <= (r_oy == OYMAX) ? '0 : r_oy + 1'b1;
          end
        end
      end
    end
  end

  // Read-in-flight stage: flags travel with the read so they meet its data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1   <= 1'b0;
      r_flags_p1 <= '0;
    end else begin
      r_vld_p1   <= w_issue;
      r_flags_p1 <= {w_win_first, w_win_last, w_frame_last};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) r_wp <= ~r_wp;
      if (w_pop)  r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // FIFO storage; contents are only observed while occupancy is non-zero.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {bus.datain3, bus.datain2, bus.datain1, bus.datain0, r_flags_p1};
  end

  assign w_head = (r_cnt != 2'd0) ? r_mem[r_rp] : '0;

  assign bus.pix_valid  = (r_cnt != 2'd0);
  assign bus.pix3       = w_head[34:27];
  assign bus.pix2       = w_head[26:19];
  assign bus.pix1       = w_head[18:11];
  assign bus.pix0       = w_head[10:3];
  assign bus.win_first  = w_head[2];
  assign bus.win_last   = w_head[1];
  assign bus.frame_last = w_head[0];
  assign bus.enb        = w_issue;
  assign bus.web        = 1'b0;
  assign bus.addrb      = w_addr;
  assign bus.busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign bus.done       = (r_state == S_DONE);
endmodule

// File: tb/tb_conv2_window_reader.sv
// Directed bench for conv2_window_reader: full frames against a BRAM model,
// a vector table of leading/trailing addresses and flags, plus hand-written
// sequences for start latency, ignored restart, mid-frame reset and a 3x3 map.
`timescale 1ns/1ps
module tb_conv2_window_reader;
  localparam int W    = 24;
  localparam int H    = 24;
  localparam int KK   = 3;
  localparam int NPIX = (W - KK + 1) * (H - KK + 1) * KK * KK;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv2_window_reader_if bus();
  conv2_window_reader_if bus3();

  conv2_window_reader #(.IMG_W(W), .IMG_H(H), .K(KK)) dut (.clk(clk), .rst(rst), .bus(bus));
  conv2_window_reader #(.IMG_W(3), .IMG_H(3), .K(3))  dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [7:0] bram(input logic [11:0] a, input int c);
    return 8'(int'(a) * 5 + c * 67 + int'(a) / 32);
  endfunction

  function automatic logic [11:0] exp_addr(input logic [11:0] base, input int idx);
    int pos, k, oy, ox, ky, kx;
    pos = idx / (KK * KK);
    k   = idx % (KK * KK);
    ky  = k / KK;
    kx  = k % KK;
    oy  = pos / (W - KK + 1);
    ox  = pos % (W - KK + 1);
    return 12'(int'(base) + (oy + ky) * W + ox + kx);
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // BRAM models: one-cycle read latency, output holds while disabled.
  logic [11:0] ra, ra3;
  always @(posedge clk) begin
    if (bus.enb)  ra  <= bus.addrb;
    if (bus3.enb) ra3 <= bus3.addrb;
  end
  assign bus.datain0  = bram(ra, 0);
  assign bus.datain1  = bram(ra, 1);
  assign bus.datain2  = bram(ra, 2);
  assign bus.datain3  = bram(ra, 3);
  assign bus3.datain0 = bram(ra3, 0);
  assign bus3.datain1 = bram(ra3, 1);
  assign bus3.datain2 = bram(ra3, 2);
  assign bus3.datain3 = bram(ra3, 3);

  // Ready driver: constant high, or the repeating 1,0,0,1 pattern.
  bit rdy_mode = 1'b0;
  initial begin
    int ph;
    logic [3:0] pat;
    ph  = 0;
    pat = 4'b1001;
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode) begin
        bus.pix_ready = pat[3 - ph];
        ph = (ph + 1) % 4;
      end else begin
        bus.pix_ready = 1'b1;
      end
    end
  end

  // Stream monitor / scoreboard for the 24x24 instance.
  bit          mon_en = 1'b0;
  int          mon_slot;
  logic [11:0] mon_base;
  int issued, popped, mon_err, done_cnt, done_bad, occ_bad, stall_bad, cyc, last_pop_cyc;
  bit          stalled;
  logic [34:0] held, cur;
  logic        m_pop;
  logic [11:0] m_a;
  logic [11:0] rec_addr  [2][NPIX];
  logic [2:0]  rec_flags [2][NPIX];

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      m_pop = bus.pix_valid && bus.pix_ready;
      cur   = {bus.pix3, bus.pix2, bus.pix1, bus.pix0, bus.win_first, bus.win_last, bus.frame_last};
      if (stalled && (!bus.pix_valid || cur != held)) stall_bad++;
      if (bus.enb) begin
        if (issued - popped - (m_pop ? 1 : 0) >= 2) occ_bad++;
        if (issued < NPIX) rec_addr[mon_slot][issued] = bus.addrb;
        if (bus.addrb != exp_addr(mon_base, issued)) mon_err++;
        issued++;
      end
      if (m_pop) begin
        m_a = exp_addr(mon_base, popped);
        if (popped < NPIX) rec_flags[mon_slot][popped] = cur[2:0];
        if (cur != {bram(m_a, 3), bram(m_a, 2), bram(m_a, 1), bram(m_a, 0),
                    (popped % (KK * KK)) == 0, (popped % (KK * KK)) == KK * KK - 1,
                    popped == NPIX - 1}) mon_err++;
        popped++;
        last_pop_cyc = cyc;
      end
      stalled = bus.pix_valid && !bus.pix_ready;
      held    = cur;
      if (bus.done) begin
        done_cnt++;
        if (last_pop_cyc != cyc - 1 || bus.busy) done_bad++;
      end
    end
  end

  task automatic mon_clear(input logic [11:0] base, input int slot);
    mon_base = base;  mon_slot = slot;
    issued = 0; popped = 0; mon_err = 0; done_cnt = 0; done_bad = 0;
    occ_bad = 0; stall_bad = 0; stalled = 1'b0; last_pop_cyc = -10;
    mon_en = 1'b1;
  endtask

  // Caller is aligned to just after a rising edge; start is sampled at the next one.
  task automatic run_frame(input string tag, input logic [11:0] base, input int slot,
                           input bit toggle, input bit restart, input bit check_lat);
    mon_clear(base, slot);
    rdy_mode = toggle;
    bus.base_addr = base;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.base_addr = 12'hABC;
    if (check_lat) begin
      @(negedge clk);
      check({tag, " busy after start"}, longint'(bus.busy), 1);
      check({tag, " valid cycle 1"}, longint'(bus.pix_valid), 0);
      @(negedge clk);
      check({tag, " valid cycle 2"}, longint'(bus.pix_valid), 0);
      @(negedge clk);
      check({tag, " valid cycle 3"}, longint'(bus.pix_valid), 1);
    end
    if (restart) begin
      repeat (100) @(posedge clk);
      #1;
      bus.base_addr = 12'd5;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    for (int i = 0; i < 25000 && done_cnt == 0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    mon_en = 1'b0;
    rdy_mode = 1'b0;
    check({tag, " pixels"}, popped, NPIX);
    check({tag, " reads issued"}, issued, NPIX);
    check({tag, " addr/data/flag errors"}, mon_err, 0);
    check({tag, " done pulses"}, done_cnt, 1);
    check({tag, " done timing"}, done_bad, 0);
    check({tag, " occupancy overrun"}, occ_bad, 0);
    check({tag, " stall hold"}, stall_bad, 0);
  endtask

  typedef struct {
    int          slot;
    int          idx;
    logic [11:0] addr;
    logic [2:0]  flags;  // {win_first, win_last, frame_last}
  } vec_t;
  vec_t tbl[14];

  initial begin
    forever begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
    end
  end

  initial begin
    logic [8:0] wf3, wl3, fl3;
    int cnt3, err3, done3;

    tbl[0]  = '{0, 0, 12'd0, 3'b100};
    tbl[1]  = '{0, 1, 12'd1, 3'b000};
    tbl[2]  = '{0, 2, 12'd2, 3'b000};
    tbl[3]  = '{0, 3, 12'd24, 3'b000};
    tbl[4]  = '{0, 4, 12'd25, 3'b000};
    tbl[5]  = '{0, 5, 12'd26, 3'b000};
    tbl[6]  = '{0, 6, 12'd48, 3'b000};
    tbl[7]  = '{0, 7, 12'd49, 3'b000};
    tbl[8]  = '{0, 8, 12'd50, 3'b010};
    tbl[9]  = '{0, NPIX - 1, 12'd575, 3'b011};
    tbl[10] = '{1, 0, 12'd4090, 3'b100};
    tbl[11] = '{1, 1, 12'd4091, 3'b000};
    tbl[12] = '{1, 2, 12'd4092, 3'b000};
    tbl[13] = '{1, 3, 12'd18, 3'b000};

    rst = 1'b1;
    bus.start = 1'b0;   bus.base_addr = '0;
    bus3.start = 1'b0;  bus3.base_addr = '0;  bus3.pix_ready = 1'b1;
    #1;
    check("reset control outputs", longint'({bus.busy, bus.done, bus.enb, bus.web, bus.pix_valid,
                                             bus.win_first, bus.win_last, bus.frame_last}), 0);
    check("reset addrb", longint'(bus.addrb), 0);
    check("reset pixels", longint'({bus.pix3, bus.pix2, bus.pix1, bus.pix0}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame("base0", 12'd0, 0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    run_frame("wrap toggle", 12'd4090, 1, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      check($sformatf("vec%0d addr", i), longint'(rec_addr[tbl[i].slot][tbl[i].idx]), longint'(tbl[i].addr));
      check($sformatf("vec%0d flags", i), longint'(rec_flags[tbl[i].slot][tbl[i].idx]), longint'(tbl[i].flags));
    end

    @(posedge clk); #1;
    run_frame("restart ignored", 12'd100, 0, 1'b0, 1'b1, 1'b0);

    // Abort a frame with reset once pixel 1000 has been accepted.
    @(posedge clk); #1;
    mon_clear(12'd7, 0);
    bus.base_addr = 12'd7;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 5000 && popped < 1000; i++) @(negedge clk);
    check("abort reached pixel 1000", popped, 1000);
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("mid-frame reset control", longint'({bus.busy, bus.done, bus.enb, bus.web, bus.pix_valid,
                                               bus.win_first, bus.win_last, bus.frame_last}), 0);
    check("mid-frame reset addrb", longint'(bus.addrb), 0);
    check("mid-frame reset pixels", longint'({bus.pix3, bus.pix2, bus.pix1, bus.pix0}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame("after reset", 12'd300, 0, 1'b0, 1'b0, 1'b1);

    // 3x3 map: a single window of nine pixels.
    @(posedge clk); #1;
    bus3.start = 1'b1;
    @(posedge clk); #1;
    bus3.start = 1'b0;
    wf3 = '0; wl3 = '0; fl3 = '0; cnt3 = 0; err3 = 0; done3 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus3.pix_valid && bus3.pix_ready) begin
        if (cnt3 < 9) begin
          wf3[cnt3] = bus3.win_first;
          wl3[cnt3] = bus3.win_last;
          fl3[cnt3] = bus3.frame_last;
          if ({bus3.pix3, bus3.pix2, bus3.pix1, bus3.pix0} !=
              {bram(12'(cnt3), 3), bram(12'(cnt3), 2), bram(12'(cnt3), 1), bram(12'(cnt3), 0)}) err3++;
        end
        cnt3++;
      end
      if (bus3.done) done3++;
    end
    check("3x3 pixel count", cnt3, 9);
    check("3x3 data errors", err3, 0);
    check("3x3 win_first", longint'(wf3), longint'(9'b000000001));
    check("3x3 win_last", longint'(wl3), longint'(9'b100000000));
    check("3x3 frame_last", longint'(fl3), longint'(9'b100000000));
    check("3x3 done pulses", done3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
